// File: rtl/rv32i_types.sv
// Shared CPU types: the common-data-bus payload and functional-unit indices.
// The CDB arbiter and the functional units that feed it both import this package.
package rv32i_types;

    localparam int NUM_CDB_PORTS = 2;
    localparam int ROB_IDX_W     = 5;

    localparam int FU_ADD = 0;
    localparam int FU_MUL = 1;
    localparam int FU_DIV = 2;
    localparam int FU_BR  = 3;
    localparam int FU_MEM = 4;

    typedef struct packed {
        logic                 valid;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [4:0]           rd;
        logic [31:0]          data;
    } cdb_t;

    // Width helper that never returns zero, so single-entry configs still elaborate.
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester/broadcast bundle between the functional units and the CDB arbiter.
interface cdb_arbiter_if #(
    parameter int NUM_FU  = 5,
    parameter int NUM_CDB = 2
);
    import rv32i_types::*;

    logic [NUM_FU-1:0]        req_valid;
    cdb_t [NUM_FU-1:0]        req_cdb;
    logic [NUM_FU-1:0]        req_ready;
    logic                     global_branch_signal;
    cdb_t [NUM_CDB-1:0]       cdb_out;
    logic [NUM_FU-1:0]        grant_vec;

    modport master (
        output req_valid, req_cdb, global_branch_signal,
        input  req_ready, cdb_out, grant_vec
    );

    modport slave (
        input  req_valid, req_cdb, global_branch_signal,
        output req_ready, cdb_out, grant_vec
    );

endinterface

// File: rtl/cdb_fifo.sv
// Per-requester holding queue: QDEPTH entries, registered ready, flush clears
// pointers and count without touching storage.
module cdb_fifo
    import rv32i_types::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush_i,
    input  logic push_i,
    input  logic pop_i,
    input  cdb_t data_i,
    output cdb_t head_o,
    output logic ready_o,
    output logic nonempty_o
);

    localparam int PW = safe_clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH) + 1;

    cdb_t          mem_q [QDEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    // Ready comes from the registered count only; a same-cycle pop never opens a slot.
    assign ready_o    = (count_q < CW'(QDEPTH));
    assign nonempty_o = (count_q != '0);
    assign head_o     = mem_q[rd_ptr_q];

    assign do_push = push_i && ready_o && !flush_i;
    assign do_pop  = pop_i && nonempty_o && !flush_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-FU holding FIFOs, rotating-priority selection of
// up to NUM_CDB heads per cycle, flush on global_branch_signal.
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int NUM_FU  = 5,
    parameter int NUM_CDB = NUM_CDB_PORTS,
    parameter int QDEPTH  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    cdb_arbiter_if.slave  bus
);

    localparam int RRW = safe_clog2(NUM_FU);
    localparam int PIW = safe_clog2(NUM_CDB);
    localparam int NSW = $clog2(NUM_CDB + 1);

    if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_qdepth
        $error("cdb_arbiter: QDEPTH must be a power of two and at least 2");
    end

    cdb_t [NUM_FU-1:0]  head;
    logic [NUM_FU-1:0]  nonempty;
    logic [NUM_FU-1:0]  ready;
    logic [NUM_FU-1:0]  grant;
    cdb_t [NUM_CDB-1:0] cdb_out;
    logic [RRW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [RRW-1:0]     idx;
    logic [NSW-1:0]     nsel;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
        cdb_fifo #(.QDEPTH(QDEPTH)) u_fifo (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush_i    (bus.global_branch_signal),
            .push_i     (bus.req_valid[i]),
            .pop_i      (grant[i]),
            .data_i     (bus.req_cdb[i]),
            .head_o     (head[i]),
            .ready_o    (ready[i]),
            .nonempty_o (nonempty[i])
        );
    end

    // Scan upward from rr_ptr; the n-th hit lands on port n, and the pointer
    // follows the last hit so the next cycle starts just past it.
    always_comb begin
        grant    = '0;
        cdb_out  = '0;
        rr_ptr_d = rr_ptr_q;
        nsel     = '0;
        idx      = '0;
        if (!bus.global_branch_signal) begin
            for (int k = 0; k < NUM_FU; k++) begin
                idx = RRW'((int'(rr_ptr_q) + k) % NUM_FU);
                if (nonempty[idx] && (int'(nsel) < NUM_CDB)) begin
                    grant[idx]            = 1'b1;
                    cdb_out[PIW'(nsel)]   = head[idx];
                    nsel                  = nsel + 1'b1;
                    rr_ptr_d              = RRW'((int'(idx) + 1) % NUM_FU);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end

    assign bus.req_ready = ready;
    assign bus.cdb_out   = cdb_out;
    assign bus.grant_vec = grant;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a queue-based reference model predicts each
// cycle's broadcast, grants, ready and rotation pointer; a monitor compares.
module tb_cdb_arbiter;
    import rv32i_types::*;

    localparam int NUM_FU  = 5;
    localparam int NUM_CDB = 2;
    localparam int QDEPTH  = 2;

    typedef struct {
        cdb_t [NUM_CDB-1:0] cdb;
        logic [NUM_FU-1:0]  grant;
        logic [NUM_FU-1:0]  ready;
        int                 rr;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_FU(NUM_FU), .NUM_CDB(NUM_CDB)) bus();

    cdb_arbiter #(.NUM_FU(NUM_FU), .NUM_CDB(NUM_CDB), .QDEPTH(QDEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    cdb_t mq [NUM_FU][$];
    int   m_rr;
    exp_t exp_q [$];

    cdb_t [NUM_CDB-1:0] obs_cdb;
    logic [NUM_FU-1:0]  obs_grant;
    logic [NUM_FU-1:0]  obs_ready;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic cdb_t [NUM_FU-1:0] mk_pl();
        cdb_t [NUM_FU-1:0] p;
        for (int i = 0; i < NUM_FU; i++) begin
            p[i].valid   = 1'b1;
            p[i].rob_idx = 5'($urandom);
            p[i].rd      = 5'($urandom);
            p[i].data    = $urandom;
        end
        return p;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NUM_FU; i++) mq[i].delete();
        m_rr = 0;
    endfunction

    // Up to NUM_CDB non-empty queues, visited in rotating order from m_rr.
    function automatic exp_t model_expect(input logic fl);
        exp_t e;
        int   n = 0;
        e.cdb   = '0;
        e.grant = '0;
        e.rr    = m_rr;
        for (int i = 0; i < NUM_FU; i++) e.ready[i] = (mq[i].size() < QDEPTH);
        if (!fl) begin
            for (int k = 0; k < NUM_FU; k++) begin
                int j = (m_rr + k) % NUM_FU;
                if (mq[j].size() > 0 && n < NUM_CDB) begin
                    e.grant[j] = 1'b1;
                    e.cdb[n]   = mq[j][0];
                    n++;
                end
            end
        end
        return e;
    endfunction

    function automatic void model_step(input exp_t e, input logic [NUM_FU-1:0] v,
                                       input logic fl, input cdb_t [NUM_FU-1:0] pl);
        int last = -1;
        if (fl) begin
            for (int i = 0; i < NUM_FU; i++) mq[i].delete();
        end else begin
            for (int k = 0; k < NUM_FU; k++) begin
                int j = (m_rr + k) % NUM_FU;
                if (e.grant[j]) begin
                    mq[j].delete(0);
                    last = j;
                end
            end
            if (last >= 0) m_rr = (last + 1) % NUM_FU;
            for (int i = 0; i < NUM_FU; i++)
                if (v[i] && e.ready[i]) mq[i].push_back(pl[i]);
        end
    endfunction

    // One clock: drive at the falling edge, predict, record, apply the model at the rising edge.
    task automatic cycle(input logic [NUM_FU-1:0] v, input logic fl, input cdb_t [NUM_FU-1:0] pl);
        exp_t              e;
        logic [NUM_FU-1:0] ve;
        @(negedge clk);
        e  = model_expect(fl);
        ve = v & e.ready;
        bus.req_cdb              = pl;
        bus.req_valid            = ve;
        bus.global_branch_signal = fl;
        exp_q.push_back(e);
        #1;
        obs_cdb   = bus.cdb_out;
        obs_grant = bus.grant_vec;
        obs_ready = bus.req_ready;
        @(posedge clk);
        model_step(e, ve, fl, pl);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, 1'b0, mk_pl());
    endtask

    task automatic reset_dut();
        @(negedge clk);
        bus.req_valid            = '0;
        bus.global_branch_signal = 1'b0;
        rst_n = 1'b0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cdb_out",   bus.cdb_out,       e.cdb);
            chk("grant_vec", bus.grant_vec,     e.grant);
            chk("req_ready", bus.req_ready,     e.ready);
            chk("rr_ptr",    int'(dut.rr_ptr_q), e.rr);
        end
    end

    always @(posedge clk) begin
        if (rst_n && |bus.req_valid)
            chk("protocol", bus.req_valid & ~bus.req_ready, '0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cdb_t [NUM_FU-1:0] pl;
        int maxw, w;
        logic saw_low, nb;

        bus.req_valid            = '0;
        bus.req_cdb              = '0;
        bus.global_branch_signal = 1'b0;
        model_clear();
        #1 rst_n = 1'b0;
        #3;
        chk("rst_ready", bus.req_ready, 5'b11111);
        chk("rst_cdb",   bus.cdb_out,   '0);
        chk("rst_grant", bus.grant_vec, '0);
        reset_dut();

        // Single add result: no bypass in the enqueue cycle, port 0 next cycle.
        pl = mk_pl();
        pl[0].rob_idx = 5'd5;
        cycle(5'b00001, 1'b0, pl);
        chk("no_bypass", obs_grant, '0);
        idle(1);
        chk("add_rob",   obs_cdb[0].rob_idx, 5'd5);
        chk("add_valid", obs_cdb[0].valid,   1'b1);
        chk("add_port1", obs_cdb[1],         '0);
        chk("add_grant", obs_grant,          5'b00001);
        chk("add_rr",    dut.rr_ptr_q,       3'd1);

        // All five at once from rr_ptr=0.
        reset_dut();
        cycle(5'b11111, 1'b0, mk_pl());
        idle(1);
        chk("all_g1", obs_grant, 5'b00011);
        chk("all_rr1", dut.rr_ptr_q, 3'd2);
        idle(1);
        chk("all_g2", obs_grant, 5'b01100);
        chk("all_rr2", dut.rr_ptr_q, 3'd4);
        idle(1);
        chk("all_g3", obs_grant, 5'b10000);
        chk("all_rr3", dut.rr_ptr_q, 3'd0);

        // Everyone requesting whenever allowed: mul must fill up yet keep being served.
        reset_dut();
        maxw = 0; w = 0; saw_low = 1'b0;
        for (int c = 0; c < 15; c++) begin
            nb = (mq[FU_MUL].size() > 0);
            cycle(5'b11111, 1'b0, mk_pl());
            if (!obs_ready[FU_MUL]) saw_low = 1'b1;
            if (nb && !obs_grant[FU_MUL]) w++;
            else w = 0;
            if (w > maxw) maxw = w;
        end
        chk("mul_ready_drop", saw_low, 1'b1);
        chk("mul_no_starve", (maxw < NUM_FU), 1'b1);
        idle(4);

        // Flush with three queued plus a new request.
        reset_dut();
        cycle(5'b00111, 1'b0, mk_pl());
        cycle(5'b01000, 1'b1, mk_pl());
        chk("flush_cdb",   obs_cdb,   '0);
        chk("flush_grant", obs_grant, '0);
        idle(1);
        chk("flush_ready", obs_ready, 5'b11111);
        chk("flush_empty", obs_grant, '0);
        chk("flush_rr",    dut.rr_ptr_q, 3'd0);

        // Asynchronous reset between edges with four entries queued.
        reset_dut();
        cycle(5'b01111, 1'b0, mk_pl());
        @(negedge clk);
        bus.req_valid = '0;
        #3 rst_n = 1'b0;
        model_clear();
        #1;
        chk("arst_ready", bus.req_ready, 5'b11111);
        chk("arst_cdb",   bus.cdb_out,   '0);
        chk("arst_grant", bus.grant_vec, '0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        chk("arst_stale", obs_grant, '0);

        // Random traffic with occasional flushes.
        reset_dut();
        for (int c = 0; c < 10000; c++)
            cycle(NUM_FU'($urandom), ($urandom_range(0, 39) == 0), mk_pl());
        idle(6);

        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
